// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares dpram port A between the CPU and a one-deep SPI
// peek/poke buffer, stalling the CPU through wait_n while SPI owns the port.
module ram_port_arbiter #(
    parameter int C_ADDR_BITS  = 16,
    parameter int C_WAIT_TICKS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_ce,
    input  logic                   cpu_mreq_n,
    input  logic                   cpu_wr_n,
    input  logic [C_ADDR_BITS-1:0] cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             cpu_din,
    input  logic                   ext_wait_n,
    output logic                   cpu_wait_n,
    input  logic                   spi_wr,
    input  logic                   spi_rd,
    input  logic [C_ADDR_BITS-1:0] spi_addr,
    input  logic [7:0]             spi_wdata,
    output logic [7:0]             spi_rdata,
    output logic                   spi_busy,
    output logic                   spi_ovf,
    output logic                   ram_we,
    output logic [C_ADDR_BITS-1:0] ram_addr,
    output logic [7:0]             ram_din,
    input  logic [7:0]             ram_dout
);

    localparam int CW = (C_WAIT_TICKS < 1) ? 1 : $clog2(C_WAIT_TICKS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(C_WAIT_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEFER,
        S_GRANT,
        S_CAPTURE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [C_ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   ovf_q, ovf_d;

    logic strobe;
    logic spi_owns;

    assign strobe = spi_wr | spi_rd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ovf_d   = ovf_q;

        // Busy strobes are dropped; a double strobe is served as a write.
        if (strobe && ((state_q != S_IDLE) || (spi_wr && spi_rd))) begin
            ovf_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    addr_d  = spi_addr;
                    wdata_d = spi_wdata;
                    wr_d    = spi_wr;
                    cnt_d   = '0;
                    state_d = cpu_mreq_n ? S_GRANT : S_DEFER;
                end
            end
            S_DEFER: begin
                if (cpu_ce && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cpu_mreq_n || (cnt_q == CNT_MAX)) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!wr_q) begin
                    rdata_d = ram_dout;
                end
                addr_d  = '0;
                wdata_d = '0;
                wr_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign spi_owns = (state_q == S_GRANT) || (state_q == S_CAPTURE);

    // A reset landing on GRANT must not let the discarded write reach RAM.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_dout;
        ram_we   = ~cpu_mreq_n & ~cpu_wr_n;
        if (spi_owns) begin
            ram_addr = addr_q;
            ram_din  = wdata_q;
            ram_we   = (state_q == S_GRANT) & wr_q & ~reset;
        end
    end

    assign cpu_din    = ram_dout;
    assign cpu_wait_n = ext_wait_n & (state_q == S_IDLE);
    assign spi_busy   = (state_q != S_IDLE);
    assign spi_rdata  = rdata_q;
    assign spi_ovf    = ovf_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus, a request-level reference model
// checked every cycle, and hand-computed spot checks.
module tb_ram_port_arbiter;

    localparam int AW = 16;
    localparam int WT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_ce = 1'b0;
    logic          cpu_mreq_n = 1'b1;
    logic          cpu_wr_n = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_dout = '0;
    logic [7:0]    cpu_din;
    logic          ext_wait_n = 1'b1;
    logic          cpu_wait_n;
    logic          spi_wr = 1'b0;
    logic          spi_rd = 1'b0;
    logic [AW-1:0] spi_addr = '0;
    logic [7:0]    spi_wdata = '0;
    logic [7:0]    spi_rdata;
    logic          spi_busy;
    logic          spi_ovf;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout = 8'h00;

    int nvec = 0;
    int nerr = 0;
    bit ce_en = 1'b0;

    ram_port_arbiter #(.C_ADDR_BITS(AW), .C_WAIT_TICKS(WT)) dut (
        .clk(clk), .reset(reset), .cpu_ce(cpu_ce),
        .cpu_mreq_n(cpu_mreq_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .ext_wait_n(ext_wait_n), .cpu_wait_n(cpu_wait_n),
        .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_addr(spi_addr),
        .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
        .spi_busy(spi_busy), .spi_ovf(spi_ovf),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous RAM behind port A.
    logic [7:0] ram_mem [0:65535] = '{default: 8'h00};
    always @(posedge clk) begin
        ram_dout <= ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_din;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: one pending request, the cycle SPI takes the port,
    // and a mirror of what RAM must hold.
    logic [7:0]    mmem [0:65535] = '{default: 8'h00};
    bit            m_pend = 1'b0;
    int            m_gnt = -1;
    int            m_ticks = 0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_wdata = '0;
    bit            m_wr = 1'b0;
    logic [7:0]    m_rdata = '0;
    bit            m_ovf = 1'b0;
    logic [7:0]    m_dout = '0;
    int            cyc = 0;

    initial begin : cmp
        bit            own;
        bit            e_we;
        bit            stb;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_din;
        logic [7:0]    nd;
        forever begin
            @(negedge clk);
            own    = m_pend && (m_gnt >= 0) && (cyc >= m_gnt);
            e_addr = own ? m_addr : cpu_addr;
            e_din  = own ? m_wdata : cpu_dout;
            e_we   = own ? (m_wr && cyc == m_gnt && !reset)
                         : (!cpu_mreq_n && !cpu_wr_n);
            if (cyc >= 2) begin
                chk("ram_we", 32'(ram_we), 32'(e_we));
                chk("ram_addr", 32'(ram_addr), 32'(e_addr));
                chk("ram_din", 32'(ram_din), 32'(e_din));
                chk("cpu_wait_n", 32'(cpu_wait_n),
                    32'(ext_wait_n && !m_pend));
                chk("spi_busy", 32'(spi_busy), 32'(m_pend));
                chk("cpu_din", 32'(cpu_din), 32'(m_dout));
                chk("spi_rdata", 32'(spi_rdata), 32'(m_rdata));
                chk("spi_ovf", 32'(spi_ovf), 32'(m_ovf));
            end
            nd = mmem[e_addr];
            if (e_we) mmem[e_addr] = e_din;
            stb = spi_wr || spi_rd;
            if (reset) begin
                m_pend  = 1'b0;
                m_gnt   = -1;
                m_ticks = 0;
                m_rdata = '0;
                m_ovf   = 1'b0;
            end else if (m_pend) begin
                if (m_gnt >= 0 && cyc == m_gnt + 1) begin
                    if (!m_wr) m_rdata = m_dout;
                    m_pend = 1'b0;
                    m_gnt  = -1;
                end else if (m_gnt < 0) begin
                    if (cpu_mreq_n || m_ticks == WT) m_gnt = cyc + 1;
                    else if (cpu_ce) m_ticks++;
                end
                if (stb) m_ovf = 1'b1;
            end else if (stb) begin
                m_pend  = 1'b1;
                m_addr  = spi_addr;
                m_wdata = spi_wdata;
                m_wr    = spi_wr;
                m_ticks = 0;
                m_gnt   = cpu_mreq_n ? cyc + 1 : -1;
                if (spi_wr && spi_rd) m_ovf = 1'b1;
            end
            m_dout = nd;
            cyc++;
        end
    end

    initial begin : ce_gen
        int n = 0;
        forever begin
            @(posedge clk);
            #1;
            cpu_ce = ce_en && (n % 4 == 0);
            n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit wr, input bit rd,
                          input logic [AW-1:0] a, input logic [7:0] d);
        spi_wr    = wr;
        spi_rd    = rd;
        spi_addr  = a;
        spi_wdata = d;
        step();
        spi_wr = 1'b0;
        spi_rd = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (spi_busy && n < 40) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("idle timeout", 32'(spi_busy), 32'h0);
    endtask

    initial begin : stim
        int  ticks;
        bit  found;
        repeat (3) step();
        reset = 1'b0;

        // Write with CPU idle
        step();
        strobe(1'b1, 1'b0, 16'h4000, 8'hA5);
        @(negedge clk);
        chk("t1 we", 32'(ram_we), 32'h1);
        chk("t1 addr", 32'(ram_addr), 32'h4000);
        chk("t1 wait", 32'(cpu_wait_n), 32'h0);
        step(); step();
        @(negedge clk);
        chk("t1 busy", 32'(spi_busy), 32'h0);
        chk("t1 mem", 32'(ram_mem[16'h4000]), 32'hA5);

        // Preload, then read with CPU idle
        step();
        strobe(1'b1, 1'b0, 16'h0123, 8'h3C);
        wait_idle();
        step();
        strobe(1'b1, 1'b0, 16'h0010, 8'h77);
        wait_idle();
        step();
        strobe(1'b0, 1'b1, 16'h0123, 8'h00);
        @(negedge clk);
        chk("t2 wait n1", 32'(cpu_wait_n), 32'h0);
        step();
        @(negedge clk);
        chk("t2 wait n2", 32'(cpu_wait_n), 32'h0);
        step();
        @(negedge clk);
        chk("t2 wait n3", 32'(cpu_wait_n), 32'h1);
        chk("t2 rdata", 32'(spi_rdata), 32'h3C);

        // CPU reading 0x0010 with cpu_ce every 4 clocks
        step();
        cpu_mreq_n = 1'b0;
        cpu_addr   = 16'h0010;
        ce_en      = 1'b1;
        step();
        strobe(1'b1, 1'b0, 16'h4001, 8'h11);
        @(negedge clk);
        chk("t3 wait", 32'(cpu_wait_n), 32'h0);
        ticks = 0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ram_we && ram_addr == 16'h4001) begin
                found = 1'b1;
                break;
            end
            if (cpu_ce) ticks++;
            step();
            @(negedge clk);
        end
        chk("t3 grant", 32'(found), 32'h1);
        chk("t3 ticks", 32'(ticks), 32'h2);
        wait_idle();
        step();
        @(negedge clk);
        chk("t3 cpu_din", 32'(cpu_din), 32'h77);
        step();
        cpu_mreq_n = 1'b1;
        ce_en      = 1'b0;

        // Second strobe while busy
        step();
        strobe(1'b1, 1'b0, 16'h4005, 8'h22);
        strobe(1'b0, 1'b1, 16'h4006, 8'h00);
        @(negedge clk);
        chk("t4 ovf", 32'(spi_ovf), 32'h1);
        wait_idle();
        chk("t4 mem1", 32'(ram_mem[16'h4005]), 32'h22);
        chk("t4 mem2", 32'(ram_mem[16'h4006]), 32'h00);

        // Reset while deferred, no cpu_ce at all
        step();
        cpu_mreq_n = 1'b0;
        cpu_addr   = 16'h0010;
        step();
        strobe(1'b1, 1'b0, 16'h4002, 8'hEE);
        repeat (6) step();
        @(negedge clk);
        chk("t5 held", 32'(spi_busy), 32'h1);
        step();
        reset      = 1'b1;
        ext_wait_n = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5 busy", 32'(spi_busy), 32'h0);
        chk("t5 rdata", 32'(spi_rdata), 32'h0);
        chk("t5 ovf", 32'(spi_ovf), 32'h0);
        chk("t5 wait", 32'(cpu_wait_n), 32'h0);
        step();
        ext_wait_n = 1'b1;
        cpu_mreq_n = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("t5 mem", 32'(ram_mem[16'h4002]), 32'h00);

        // ext_wait_n low does not block the arbiter
        step();
        ext_wait_n = 1'b0;
        strobe(1'b0, 1'b1, 16'h4001, 8'h00);
        step(); step();
        @(negedge clk);
        chk("t6 rdata", 32'(spi_rdata), 32'h11);
        chk("t6 busy", 32'(spi_busy), 32'h0);
        step();
        ext_wait_n = 1'b1;

        // CPU write during DEFER, SPI write lands last
        step();
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        cpu_addr   = 16'h4003;
        cpu_dout   = 8'h55;
        strobe(1'b1, 1'b0, 16'h4003, 8'h99);
        @(negedge clk);
        chk("t7 cpu we", 32'(ram_we), 32'h1);
        chk("t7 cpu din", 32'(ram_din), 32'h55);
        step();
        cpu_mreq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        wait_idle();
        chk("t7 mem", 32'(ram_mem[16'h4003]), 32'h99);

        // spi_wr and spi_rd together
        step();
        strobe(1'b1, 1'b1, 16'h4007, 8'h5A);
        wait_idle();
        chk("t8 mem", 32'(ram_mem[16'h4007]), 32'h5A);
        chk("t8 ovf", 32'(spi_ovf), 32'h1);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
